// File: rtl/types_pkg.sv
// Shared types and constants for the rename stage.
//   decode_data : decoded instruction arriving from the frontend
//   rename_data : renamed instruction handed to dispatch
//   NUM_PREGS / PREG_W : physical register file size and tag width
//   OPC_*       : RV32 major opcodes used to classify instructions
package types_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned FL_DEPTH  = 32;
  localparam int unsigned FL_PTR_W  = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [4:0]        areg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } decode_data;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    preg_t       prs1;
    preg_t       prs2;
    preg_t       prd;
    preg_t       old_prd;
    logic        has_rd;
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } rename_data;

  // Opcodes whose instructions write an architectural destination.
  function automatic logic writes_rd(input logic [6:0] op);
    logic w;
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_SYSTEM: w = 1'b1;
      default:                                 w = 1'b0;
    endcase
    return w;
  endfunction

  // Control-flow instructions that need a map checkpoint.
  function automatic logic is_branch_op(input logic [6:0] op);
    return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags.
//   pop_i/head_preg_o   : allocate the tag at head
//   push_i/push_preg_i  : return a retired tag at tail
//   restore_i/restore_head_i : rewind head to a checkpointed value
//   head_o, count_o     : head pointer (with wrap bit) and tail - head
module free_list
  import types_pkg::*;
(
  input  logic                clk,
  input  logic                rst_ni,
  input  logic                pop_i,
  input  logic                push_i,
  input  preg_t               push_preg_i,
  input  logic                restore_i,
  input  logic [FL_PTR_W-1:0] restore_head_i,
  output preg_t               head_preg_o,
  output logic [FL_PTR_W-1:0] head_o,
  output logic [FL_PTR_W-1:0] count_o
);

  preg_t               slots_q [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_q, head_d;
  logic [FL_PTR_W-1:0] tail_q, tail_d;

  always_comb begin
    head_d = head_q;
    if (restore_i) begin
      head_d = restore_head_i;
    end else if (pop_i) begin
      head_d = head_q + FL_PTR_W'(1);
    end
  end

  // Tail is never rewound: returned tags stay free across a flush.
  always_comb begin
    tail_d = tail_q;
    if (push_i) begin
      tail_d = tail_q + FL_PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        slots_q[i] <= preg_t'(FL_DEPTH + i);
      end
      head_q <= '0;
      tail_q <= FL_PTR_W'(FL_DEPTH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (push_i) begin
        slots_q[tail_q[FL_PTR_W-2:0]] <= push_preg_i;
      end
    end
  end

  assign head_preg_o = slots_q[head_q[FL_PTR_W-2:0]];
  assign head_o      = head_q;
  assign count_o     = tail_q - head_q;

endmodule

// File: rtl/rename.sv
// Register rename stage: maps architectural to physical registers,
// allocates destinations from the free list and keeps one branch
// checkpoint of the map table and free-list head.
//   valid_in/data_in/ready_out    : decoded instruction from frontend
//   valid_out/data_out/ready_in   : renamed instruction to dispatch
//   mispredict/branch_resolved    : checkpoint restore / release
//   commit_valid/commit_preg      : retired tag returned to free list
module rename
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  decode_data data_in,
  output logic       ready_out,
  output logic       valid_out,
  output rename_data data_out,
  input  logic       ready_in,
  input  logic       mispredict,
  input  logic       branch_resolved,
  input  logic       commit_valid,
  input  preg_t      commit_preg
);

  preg_t               map_q      [NUM_AREGS];
  preg_t               map_d      [NUM_AREGS];
  preg_t               ckpt_map_q [NUM_AREGS];
  preg_t               ckpt_map_d [NUM_AREGS];
  logic [FL_PTR_W-1:0] ckpt_head_q, ckpt_head_d;
  logic                ckpt_valid_q, ckpt_valid_d;
  logic                valid_q, valid_d;
  rename_data          data_q, data_d;

  logic                needs_rd;
  logic                is_branch;
  logic                transfer;
  logic                alloc;
  logic                restore;
  preg_t               fl_head_preg;
  logic [FL_PTR_W-1:0] fl_head;
  logic [FL_PTR_W-1:0] fl_count;

  assign needs_rd  = (data_in.rd != '0) && writes_rd(data_in.opcode);
  assign is_branch = is_branch_op(data_in.opcode);

  // A commit this cycle is not visible in fl_count, so an empty free list
  // stalls even when a tag is being returned.
  assign ready_out = !mispredict && (!valid_q || ready_in)
                  && (!needs_rd || fl_count != '0)
                  && (!is_branch || !ckpt_valid_q);

  assign transfer = valid_in && ready_out;
  assign alloc    = transfer && needs_rd;
  assign restore  = mispredict && ckpt_valid_q;

  free_list u_free_list (
    .clk            (clk),
    .rst_ni         (reset),
    .pop_i          (alloc),
    .push_i         (commit_valid),
    .push_preg_i    (commit_preg),
    .restore_i      (restore),
    .restore_head_i (ckpt_head_q),
    .head_preg_o    (fl_head_preg),
    .head_o         (fl_head),
    .count_o        (fl_count)
  );

  always_comb begin
    map_d = map_q;
    if (restore) begin
      map_d = ckpt_map_q;
    end else if (alloc) begin
      map_d[data_in.rd] = fl_head_preg;
    end
  end

  // The checkpoint captures the map including the branch's own write
  // (JAL/JALR), and the head after its allocation.
  always_comb begin
    ckpt_map_d   = ckpt_map_q;
    ckpt_head_d  = ckpt_head_q;
    ckpt_valid_d = ckpt_valid_q;
    if (transfer && is_branch) begin
      ckpt_map_d   = map_d;
      ckpt_head_d  = alloc ? fl_head + FL_PTR_W'(1) : fl_head;
      ckpt_valid_d = 1'b1;
    end else if (mispredict || branch_resolved) begin
      ckpt_valid_d = 1'b0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (mispredict) begin
      valid_d = 1'b0;
    end else if (transfer) begin
      valid_d        = 1'b1;
      data_d.pc      = data_in.pc;
      data_d.opcode  = data_in.opcode;
      data_d.prs1    = map_q[data_in.rs1];
      data_d.prs2    = map_q[data_in.rs2];
      data_d.prd     = needs_rd ? fl_head_preg : '0;
      data_d.old_prd = map_q[data_in.rd];
      data_d.has_rd  = needs_rd;
      data_d.rs1     = data_in.rs1;
      data_d.rs2     = data_in.rs2;
      data_d.rd      = data_in.rd;
      data_d.imm     = data_in.imm;
      data_d.funct3  = data_in.funct3;
      data_d.funct7  = data_in.funct7;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_AREGS; i++) begin
        map_q[i]      <= preg_t'(i);
        ckpt_map_q[i] <= preg_t'(i);
      end
      ckpt_head_q  <= '0;
      ckpt_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      map_q        <= map_d;
      ckpt_map_q   <= ckpt_map_d;
      ckpt_head_q  <= ckpt_head_d;
      ckpt_valid_q <= ckpt_valid_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_rename.sv
// Self-checking bench for rename: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_rename;
  import types_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  decode_data data_in;
  logic       ready_out;
  logic       valid_out;
  rename_data data_out;
  logic       ready_in;
  logic       mispredict;
  logic       branch_resolved;
  logic       commit_valid;
  preg_t      commit_preg;

  always #5 clk = ~clk;

  rename dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .ready_out       (ready_out),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .ready_in        (ready_in),
    .mispredict      (mispredict),
    .branch_resolved (branch_resolved),
    .commit_valid    (commit_valid),
    .commit_preg     (commit_preg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: map as an array, free list as a queue of tags.
  // A checkpoint keeps the map and the free queue; tags returned after it
  // are appended again on restore because returns are never undone.
  preg_t      m_map      [32];
  preg_t      m_ckpt_map [32];
  preg_t      m_free[$];
  preg_t      m_ckpt_free[$];
  preg_t      m_since[$];
  logic       m_ckpt_valid;
  logic       m_vo;
  rename_data m_do;
  logic       last_rdy;

  localparam logic [6:0] ADDI = 7'h13;
  localparam logic [6:0] ADD  = 7'h33;
  localparam logic [6:0] BEQ  = 7'h63;
  localparam logic [6:0] SW   = 7'h23;
  localparam logic [6:0] JAL  = 7'h6f;

  function automatic logic m_writes(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33, 7'h73};
  endfunction

  function automatic logic m_branch(input logic [6:0] op);
    return op inside {7'h63, 7'h6f, 7'h67};
  endfunction

  function automatic decode_data mk(input logic [6:0] op, input int rd,
                                    input int rs1, input int rs2);
    decode_data d;
    d.pc     = $urandom;
    d.opcode = op;
    d.rd     = 5'(rd);
    d.rs1    = 5'(rs1);
    d.rs2    = 5'(rs2);
    d.imm    = $urandom;
    d.funct3 = 3'($urandom);
    d.funct7 = 7'($urandom);
    return d;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = preg_t'(i);
    m_free.delete();
    for (int i = 32; i < 64; i++) m_free.push_back(preg_t'(i));
    m_ckpt_free.delete();
    m_since.delete();
    m_ckpt_valid = 1'b0;
    m_vo         = 1'b0;
    m_do         = '0;
  endtask

  // One clock: drive inputs, check ready_out, advance model, check outputs.
  task automatic cycle(input string tag, input logic vi, input decode_data d,
                       input logic ri, input logic mp, input logic brr,
                       input logic cv, input preg_t cp);
    logic nd, br, exp_rdy, xfer;
    valid_in = vi; data_in = d; ready_in = ri; mispredict = mp;
    branch_resolved = brr; commit_valid = cv; commit_preg = cp;
    #1;
    nd = (d.rd != 5'd0) && m_writes(d.opcode);
    br = m_branch(d.opcode);
    exp_rdy = !mp && (!m_vo || ri) && (!nd || m_free.size() != 0)
           && (!br || !m_ckpt_valid);
    last_rdy = ready_out;
    check({tag, ".ready"}, 128'(ready_out), 128'(exp_rdy));
    xfer = vi && exp_rdy;
    if (xfer) begin
      m_do         = '0;
      m_do.pc      = d.pc;   m_do.opcode = d.opcode;
      m_do.rs1     = d.rs1;  m_do.rs2    = d.rs2;    m_do.rd = d.rd;
      m_do.imm     = d.imm;  m_do.funct3 = d.funct3; m_do.funct7 = d.funct7;
      m_do.prs1    = m_map[d.rs1];
      m_do.prs2    = m_map[d.rs2];
      m_do.old_prd = m_map[d.rd];
      m_do.has_rd  = nd;
      m_do.prd     = nd ? m_free[0] : preg_t'(0);
      if (nd) begin
        void'(m_free.pop_front());
        m_map[d.rd] = m_do.prd;
      end
      m_vo = 1'b1;
      if (br) begin
        m_ckpt_map   = m_map;
        m_ckpt_free  = m_free;
        m_since.delete();
        m_ckpt_valid = 1'b1;
      end else if (brr) begin
        m_ckpt_valid = 1'b0;
      end
    end else if (mp) begin
      if (m_ckpt_valid) begin
        m_map  = m_ckpt_map;
        m_free = {m_ckpt_free, m_since};
      end
      m_ckpt_valid = 1'b0;
      m_vo         = 1'b0;
    end else begin
      if (brr) m_ckpt_valid = 1'b0;
      if (m_vo && ri) m_vo = 1'b0;
    end
    if (cv) begin
      m_free.push_back(cp);
      m_since.push_back(cp);
    end
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 128'(valid_out), 128'(m_vo));
    if (m_vo) check({tag, ".data"}, 128'(data_out), 128'(m_do));
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, mk(ADDI, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    valid_in = 1'b0; mispredict = 1'b0; branch_resolved = 1'b0;
    commit_valid = 1'b0; ready_in = 1'b1;
    #2 reset = 1'b0;
    #1;
    check({tag, ".rst_valid"}, 128'(valid_out), 128'(0));
    check({tag, ".rst_data"},  128'(data_out),  128'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  decode_data d0;
  logic       rv, rr, rm, rb, rc;
  preg_t      rp;

  initial begin
    reset = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
    mispredict = 1'b0; branch_resolved = 1'b0; commit_valid = 1'b0;
    commit_preg = '0;
    model_reset();
    #12;
    check("reset.valid", 128'(valid_out), 128'(0));
    check("reset.data",  128'(data_out),  128'(0));
    @(negedge clk);
    reset = 1'b1;

    // Sequential rename
    cycle("seq0", 1'b1, mk(ADDI, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("seq0.prd", 128'(data_out.prd), 128'(32));
    check("seq0.old", 128'(data_out.old_prd), 128'(1));
    cycle("seq1", 1'b1, mk(ADDI, 2, 1, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("seq1.prs1", 128'(data_out.prs1), 128'(32));
    check("seq1.prd",  128'(data_out.prd),  128'(33));
    idle("seq2");

    // Backpressure: held output, stalled input, no allocation meanwhile
    cycle("bp0", 1'b1, mk(ADDI, 5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    d0 = mk(ADDI, 6, 5, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold", 1'b1, d0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("bp_hold.stall", 128'(last_rdy), 128'(0));
      check("bp_hold.prd", 128'(data_out.prd), 128'(34));
    end
    cycle("bp_go", 1'b1, d0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("bp_go.prd",  128'(data_out.prd),  128'(35));
    check("bp_go.prs1", 128'(data_out.prs1), 128'(34));
    idle("bp_end");

    // Mispredict restore to a checkpoint taken at head 0
    do_reset("mp");
    cycle("mp_br", 1'b1, mk(BEQ, 0, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle("mp_x3", 1'b1, mk(ADDI, 3, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle("mp_x4", 1'b1, mk(ADDI, 4, 3, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("mp_x4.prd", 128'(data_out.prd), 128'(33));
    cycle("mp_flush", 1'b1, mk(ADDI, 9, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("mp_flush.valid", 128'(valid_out), 128'(0));
    cycle("mp_after", 1'b1, mk(ADD, 7, 3, 4), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("mp_after.prs1", 128'(data_out.prs1), 128'(3));
    check("mp_after.prs2", 128'(data_out.prs2), 128'(4));
    check("mp_after.prd",  128'(data_out.prd),  128'(32));

    // Second branch stalls until the checkpoint is released
    cycle("br1", 1'b1, mk(JAL, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    d0 = mk(BEQ, 0, 1, 7);
    cycle("br2_stall", 1'b1, d0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("br2_stall.rdy", 128'(last_rdy), 128'(0));
    cycle("br2_res", 1'b1, d0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle("br2_go", 1'b1, d0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("br2_go.rdy", 128'(last_rdy), 128'(1));
    cycle("br2_x8", 1'b1, mk(ADDI, 8, 1, 0), 1'b1, 1'b0, 1'b0, 1'b1, 6'd50);
    cycle("br2_flush", 1'b0, mk(ADDI, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle("br2_chk", 1'b1, mk(ADD, 10, 8, 1), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    // New branch coinciding with branch_resolved keeps its checkpoint
    cycle("br3", 1'b1, mk(BEQ, 0, 2, 3), 1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle("br3_x3", 1'b1, mk(ADDI, 3, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle("br3_flush", 1'b0, mk(ADDI, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle("br3_chk", 1'b1, mk(ADD, 11, 3, 10), 1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Exhaustion and no bypass of a same-cycle commit
    do_reset("ex");
    for (int i = 0; i < 32; i++)
      cycle("ex_fill", 1'b1, mk(ADDI, (i % 31) + 1, 0, 0), 1'b1, 1'b0,
            1'b0, 1'b0, '0);
    check("ex_fill.last", 128'(data_out.prd), 128'(63));
    d0 = mk(ADDI, 12, 1, 2);
    cycle("ex_stall", 1'b1, d0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
    check("ex_stall.rdy", 128'(last_rdy), 128'(0));
    cycle("ex_go", 1'b1, d0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("ex_go.prd", 128'(data_out.prd), 128'(5));
    // Allocation and commit together keep the count level
    cycle("ex_c1", 1'b0, d0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd7);
    cycle("ex_both", 1'b1, mk(ADDI, 13, 0, 0), 1'b1, 1'b0, 1'b0, 1'b1, 6'd9);
    check("ex_both.prd", 128'(data_out.prd), 128'(7));
    cycle("ex_next", 1'b1, mk(ADDI, 14, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("ex_next.prd", 128'(data_out.prd), 128'(9));
    cycle("ex_empty", 1'b1, mk(ADDI, 15, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("ex_empty.rdy", 128'(last_rdy), 128'(0));

    // Reset mid-stream, then rename in the first cycle after release
    cycle("rs_pre", 1'b1, mk(JAL, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, '0);
    do_reset("rs");
    cycle("rs_first", 1'b1, mk(ADDI, 3, 3, 9), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("rs_first.prs1", 128'(data_out.prs1), 128'(3));
    check("rs_first.prs2", 128'(data_out.prs2), 128'(9));
    check("rs_first.prd",  128'(data_out.prd),  128'(32));

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic [6:0] ops [10];
      ops = '{7'h13, 7'h33, 7'h03, 7'h37, 7'h63, 7'h6f, 7'h67, 7'h23,
              7'h0f, 7'h7f};
      d0 = mk(ops[$urandom_range(0, 9)], $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      rm = ($urandom_range(0, 19) == 0);
      rb = ($urandom_range(0, 9) == 0);
      rc = ($urandom_range(0, 1) == 0) && (m_free.size() < 32)
        && (!m_ckpt_valid || (m_ckpt_free.size() + m_since.size()) < 32);
      rp = preg_t'($urandom_range(1, 63));
      cycle("rnd", rv, d0, rr, rm, rb, rc, rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
